// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions.
// Fetch FSM encoding, constants and IF/ID bundle.
package rv_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [6:0] OP_LW    = 7'd3;
  localparam logic [6:0] OP_SW    = 7'd35;
  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_BTYPE = 7'd99;
  localparam logic [6:0] OP_ITYPE = 7'd19;
  localparam logic [6:0] OP_JAL   = 7'd111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer for a fetched word.
// Clear wins over load so a redirect always drops it.
module fetch_skid #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // next buffer contents
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  // buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Handles stall skid, redirect and drain of in-flight fetch.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcSrc,
  input  logic [31:0] pcTarget,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  if_id_t       ifid_q, ifid_d;
  logic         vld_q, vld_d;
  logic         mis_q, mis_d;

  logic         ack;
  logic [31:0]  pc_plus4f;
  logic [31:0]  tgt;
  logic         buf_load, buf_clr, buf_valid;
  if_id_t       buf_din, buf_dout;

  assign imemReq   = rst_n & (state_q != HOLD);
  assign imemAddr  = pc_q;
  assign ack       = imemAck & imemReq;
  assign pc_plus4f = pc_q + 32'd4;
  assign tgt       = align4(pcTarget);
  assign buf_din   = '{instr: imemRdata,
                       pc: pc_q,
                       pc_plus4: pc_plus4f};

  fetch_skid #(.W($bits(if_id_t))) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clr),
    .din   (buf_din),
    .dout  (buf_dout),
    .valid (buf_valid)
  );

  // next state, fetch PC and IF/ID contents
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    ifid_d   = ifid_q;
    vld_d    = vld_q;
    mis_d    = 1'b0;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    if (pcSrc) begin
      mis_d        = |pcTarget[1:0];
      vld_d        = 1'b0;
      ifid_d.instr = NOP_INSTR;
      buf_clr      = 1'b1;
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = tgt;
          end else begin
            tgt_d   = tgt;
            state_d = DRAIN;
          end
        end
        HOLD: begin
          pc_d    = tgt;
          state_d = FETCH;
        end
        DRAIN: begin
          if (ack) begin
            pc_d    = tgt;
            state_d = FETCH;
          end else begin
            tgt_d = tgt;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack && !stall) begin
            ifid_d = buf_din;
            vld_d  = 1'b1;
            pc_d   = pc_plus4f;
          end else if (ack) begin
            buf_load = 1'b1;
            pc_d     = pc_plus4f;
            state_d  = HOLD;
          end else if (!stall) begin
            vld_d        = 1'b0;
            ifid_d.instr = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d  = buf_dout;
            vld_d   = buf_valid;
            buf_clr = 1'b1;
            state_d = FETCH;
            if (!buf_valid) ifid_d.instr = NOP_INSTR;
          end
        end
        DRAIN: begin
          if (ack) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // state and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ifid_q  <= '{instr: NOP_INSTR,
                   pc: '0,
                   pc_plus4: '0};
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ifid_q  <= ifid_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  assign instrValid = vld_q;
  assign instr      = ifid_q.instr;
  assign pcD        = ifid_q.pc;
  assign pcPlus4D   = ifid_q.pc_plus4;
  assign misaligned = mis_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 pcSrc  in  1  redirect request from branch/jump resolution (branch&zero | jump).
REQ-004 pcTarget  in  32  redirect address; valid only while pcSrc=1.
REQ-005 stall  in  1  decode cannot accept; IF/ID register holds.
REQ-006 imemReq  out  1  instruction memory request.
REQ-007 imemAddr  out  32  word-aligned fetch address.
REQ-008 imemAck  in  1  imemRdata valid this cycle; ignored while imemReq=0.
REQ-009 imemRdata  in  32  fetched instruction word.
REQ-010 instrValid  out  1  IF/ID holds a real instruction.
REQ-011 instr  out  32  IF/ID instruction; instr[6:0] drives the decoder op input.
REQ-012 pcD  out  32  PC of instr.
REQ-013 pcPlus4D  out  32  pcD+4, link value for jal write-back.
REQ-014 misaligned  out  1  one-cycle pulse: pcTarget[1:0]!=0 at redirect.
REQ-015 RESET_PC  parameter, default 32'h0000_0000, first fetch address.

Function
REQ-016 States SHALL be FETCH, HOLD, DRAIN; pcF register holds the current fetch address.
REQ-017 FETCH: imemReq=1, imemAddr=pcF; imemReq and imemAddr SHALL stay stable until imemAck.
REQ-018 FETCH, ack, stall=0, pcSrc=0: IF/ID <= {rdata, pcF, pcF+4}, instrValid<=1, pcF<=pcF+4, remain FETCH.
REQ-019 FETCH, ack, stall=1, pcSrc=0: rdata captured into skid buffer, pcF<=pcF+4, ->HOLD; IF/ID unchanged.
REQ-020 HOLD: imemReq=0; when stall=0, IF/ID <= buffer, ->FETCH the same edge.
REQ-021 FETCH, no ack, stall=0: instrValid<=0, instr<=NOP (32'h0000_0013) (bubble).
REQ-022 pcSrc=1 SHALL have priority over stall and ack in every state: IF/ID flushed (instrValid<=0, instr<=NOP), buffer discarded.
REQ-023 pcSrc=1 in FETCH with ack, or in HOLD: pcF<=pcTarget, ->FETCH; the new request is issued the next cycle.
REQ-024 pcSrc=1 in FETCH without ack: pcTarget latched, ->DRAIN; request stays outstanding at the old address.
REQ-025 DRAIN: imemReq=1 at the old address; on ack, rdata discarded, pcF<=latched target, ->FETCH.
REQ-026 pcSrc=1 in DRAIN: the latched target is overwritten with the newest pcTarget.
REQ-027 pcTarget[1:0]!=0: low bits forced to 00 and misaligned pulsed for one cycle.
REQ-028 Address arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 Fetch-to-IF/ID latency with same-cycle ack SHALL be 1 cycle; throughput 1 instr/cycle.
REQ-030 instr SHALL equal NOP whenever instrValid=0.

Reset
REQ-031 While rst_n=0: state=FETCH, pcF=RESET_PC, imemReq=0, instrValid=0, instr=NOP, pcD=0, pcPlus4D=0, misaligned=0, buffer cleared.
REQ-032 First cycle after rst_n rises: imemReq=1, imemAddr=RESET_PC.
REQ-033 Reset mid-request SHALL abandon the transaction; a late ack after reset is treated as a new-fetch ack only if imemReq=1.

Structure
REQ-034 Shared package rv_pkg SHALL hold RESET_PC default, NOP_INSTR, fetch state encoding, opcode constants (LW=3, SW=35, RTYPE=51, BTYPE=99, ITYPE=19, JAL=111).
REQ-035 The skid buffer SHALL be the single sub-module fetch_skid (data, valid, load, clear).

Verification
REQ-036 Reset release, ack every cycle, rdata=addr-tagged -> imemAddr 0,4,8,…; instrValid rises 1 cycle after first ack; pcPlus4D=pcD+4.
REQ-037 stall=1 for 3 cycles on ack at pcF=8 -> HOLD, imemReq=0, pcD/instr frozen; on release instr=word@8, next fetch addr 12.
REQ-038 pcSrc=1, pcTarget=0x40 with ack same cycle -> instrValid=0, instr=0x13, next imemAddr=0x40.
REQ-039 pcSrc=1, pcTarget=0x80 while ack withheld 4 cycles -> imemAddr held at old value until ack, data dropped, then imemAddr=0x80.
REQ-040 pcTarget=0x102 -> misaligned=1 one cycle, next imemAddr=0x100.
REQ-041 pcSrc=1 and stall=1 same cycle in HOLD -> buffer dropped, IF/ID flushed, fetch resumes at pcTarget.
